// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs a req/ack data-memory transaction for
// LOAD/STORE and passes the ALU result through for every other instruction.
// Misaligned accesses and unsupported funct3 encodings fault without touching
// memory.
module mem_access #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halt,
    input  logic            taken_branch,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instruction_in,
    input  logic [XLEN-1:0] alu_in,
    input  logic [XLEN-1:0] rs2_in,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] instruction_out,
    output logic [XLEN-1:0] result_out,
    output logic            fault_out
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state, next_state;

    // Decode of the instruction currently offered by execute
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [1:0]      addr_lo;
    logic            is_load, is_store, is_mem;
    logic            legal_f3, misaligned, access_fault;
    logic            take;
    logic [3:0]      be_next;
    logic [XLEN-1:0] wdata_next;

    // Context of the outstanding memory access, needed when the ack arrives
    logic [XLEN-1:0] pend_instr;
    logic [XLEN-1:0] pend_alu;
    logic [2:0]      pend_f3;
    logic [1:0]      pend_off;
    logic            pend_store;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] load_data;

    // Decode, fault detection and byte-lane steering for the incoming instruction
    always_comb begin
        opcode   = instruction_in[6:0];
        funct3   = instruction_in[14:12];
        addr_lo  = alu_in[1:0];
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        is_mem   = is_load || is_store;

        legal_f3 = is_load  ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) :
                   is_store ? (funct3 inside {3'b000, 3'b001, 3'b010}) : 1'b0;
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        access_fault = is_mem && (!legal_f3 || misaligned);

        // NOTE: every combinational output gets a default first so no path can infer a latch.
        be_next    = 4'b1111;
        wdata_next = rs2_in;
        case (funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr_lo;
                wdata_next = {4{rs2_in[7:0]}};
            end
            2'b01: begin
                be_next    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{rs2_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Next-state logic and state-derived handshake outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        mem_req    = 1'b0;
        take       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                take     = in_valid && !halt && !taken_branch;
                if (take)
                    next_state = (is_mem && !access_fault) ? ACCESS : RESP;
            end
            ACCESS: begin
                mem_req = 1'b1;
                if (mem_ack)
                    next_state = IDLE;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Align the returned word and apply sign/zero extension
    always_comb begin
        lane = mem_rdata >> {pend_off, 3'b000};
        case (pend_f3)
            3'b000:  load_data = {{(XLEN-8){lane[7]}},   lane[7:0]};
            3'b001:  load_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}},      lane[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}},     lane[15:0]};
            default: load_data = lane;
        endcase
    end

    // Capture per-access context; only read after it has been written
    always_ff @(posedge clk) begin
        // NOTE: these context registers are always written before use, so they carry no reset.
        if (take && is_mem && !access_fault) begin
            pend_instr <= instruction_in;
            pend_alu   <= alu_in;
            pend_f3    <= funct3;
            pend_off   <= addr_lo;
            pend_store <= is_store;
        end
    end

    // Memory request fields and write-back result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_be          <= 4'b0000;
            mem_wdata       <= '0;
            out_valid       <= 1'b0;
            instruction_out <= '0;
            result_out      <= '0;
            fault_out       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (take) begin
                if (is_mem && !access_fault) begin
                    mem_we    <= is_store;
                    mem_addr  <= {alu_in[XLEN-1:2], 2'b00};
                    mem_be    <= be_next;
                    mem_wdata <= wdata_next;
                end else begin
                    out_valid       <= 1'b1;
                    instruction_out <= instruction_in;
                    result_out      <= access_fault ? '0 : alu_in;
                    fault_out       <= access_fault;
                end
            end
            if (state == ACCESS && mem_ack) begin
                out_valid       <= 1'b1;
                instruction_out <= pend_instr;
                result_out      <= pend_store ? pend_alu : load_data;
                fault_out       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: reset, pass-through, loads, stores, faults,
// squash, halt, reset mid-access and back-to-back issue.
module tb_mem_access;

    localparam logic [31:0] I_ADD = 32'h003100B3;
    localparam logic [31:0] I_LB  = 32'h00010083;
    localparam logic [31:0] I_LBU = 32'h00014083;
    localparam logic [31:0] I_LW  = 32'h00012083;
    localparam logic [31:0] I_SH  = 32'h00311023;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic        taken_branch = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction_in = '0;
    logic [31:0] alu_in = '0;
    logic [31:0] rs2_in = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic [31:0] instruction_out;
    logic [31:0] result_out;
    logic        fault_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt), .taken_branch(taken_branch),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction_in(instruction_in), .alu_in(alu_in), .rs2_in(rs2_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .instruction_out(instruction_out),
        .result_out(result_out), .fault_out(fault_out)
    );

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; instruction_in = I_LW; alu_in = 32'h40;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) step();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        checks++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin failures++; $display("FAIL reset_mem_fields got=%0h/%0h/%0h/%0h exp=0", mem_we, mem_be, mem_addr, mem_wdata); end
        checks++; if ({fault_out, instruction_out, result_out} !== '0) begin failures++; $display("FAIL reset_wb_fields got=%0h/%0h/%0h exp=0", fault_out, instruction_out, result_out); end
        in_valid = 1'b0; mem_ack = 1'b0; rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
        checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_release_idle got req=%0h ov=%0h exp=0/0", mem_req, out_valid); end
    endtask

    task automatic test_alu_pass();
        in_valid = 1'b1; instruction_in = I_ADD; alu_in = 32'h0000_1234;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%0h exp=1", out_valid); end
        checks++; if (result_out !== 32'h0000_1234) begin failures++; $display("FAIL add_result got=%h exp=00001234", result_out); end
        checks++; if (fault_out !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL add_fault_req got=%0h/%0h exp=0/0", fault_out, mem_req); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL add_busy_in_ready got=%0h exp=0", in_ready); end
        checks++; if (instruction_out !== I_ADD) begin failures++; $display("FAIL add_instr got=%h exp=%h", instruction_out, I_ADD); end
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL add_after got ov=%0h rdy=%0h req=%0h exp=0/1/0", out_valid, in_ready, mem_req); end
    endtask

    task automatic test_load_byte(input logic [31:0] instr, input logic [31:0] exp_result, input string name);
        in_valid = 1'b1; instruction_in = instr; alu_in = 32'h0000_0103;
        step();
        in_valid = 1'b0;
        checks++; if (mem_addr !== 32'h100 || mem_be !== 4'b1000 || mem_we !== 1'b0) begin failures++; $display("FAIL %s_req_fields got addr=%h be=%b we=%0h exp=100/1000/0", name, mem_addr, mem_be, mem_we); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_req !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL %s_wait%0d got req=%0h ov=%0h exp=1/0", name, i, mem_req, out_valid); end
            step();
        end
        mem_ack = 1'b1; mem_rdata = 32'h80FF_0011;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL %s_held got req=%0h addr=%h exp=1/100", name, mem_req, mem_addr); end
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        checks++; if (out_valid !== 1'b1 || mem_req !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL %s_done got ov=%0h req=%0h rdy=%0h exp=1/0/1", name, out_valid, mem_req, in_ready); end
        checks++; if (result_out !== exp_result || fault_out !== 1'b0) begin failures++; $display("FAIL %s_result got=%h fault=%0h exp=%h/0", name, result_out, fault_out, exp_result); end
        step();
        checks++; if (out_valid !== 1'b0 || result_out !== exp_result) begin failures++; $display("FAIL %s_hold got ov=%0h res=%h exp=0/%h", name, out_valid, result_out, exp_result); end
    endtask

    task automatic test_store_half();
        in_valid = 1'b1; instruction_in = I_SH; alu_in = 32'h0000_2002; rs2_in = 32'hDEAD_BEEF;
        step();
        in_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL sh_req got req=%0h we=%0h exp=1/1", mem_req, mem_we); end
        checks++; if (mem_be !== 4'b1100 || mem_addr !== 32'h2000) begin failures++; $display("FAIL sh_be_addr got be=%b addr=%h exp=1100/2000", mem_be, mem_addr); end
        checks++; if (mem_wdata !== 32'hBEEF_BEEF) begin failures++; $display("FAIL sh_wdata got=%h exp=beefbeef", mem_wdata); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++; if (out_valid !== 1'b1 || result_out !== 32'h2002 || fault_out !== 1'b0) begin failures++; $display("FAIL sh_result got ov=%0h res=%h f=%0h exp=1/2002/0", out_valid, result_out, fault_out); end
        step();
    endtask

    task automatic test_misaligned();
        in_valid = 1'b1; instruction_in = I_LW; alu_in = 32'h0000_0006;
        step();
        in_valid = 1'b0;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL misal_req got=%0h exp=0", mem_req); end
        checks++; if (out_valid !== 1'b1 || fault_out !== 1'b1 || result_out !== 32'h0) begin failures++; $display("FAIL misal_result got ov=%0h f=%0h res=%h exp=1/1/0", out_valid, fault_out, result_out); end
        step();
        checks++; if (out_valid !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL misal_after got ov=%0h req=%0h rdy=%0h exp=0/0/1", out_valid, mem_req, in_ready); end
    endtask

    task automatic test_squash();
        in_valid = 1'b1; taken_branch = 1'b1; instruction_in = I_LW; alu_in = 32'h10;
        step();
        in_valid = 1'b0; taken_branch = 1'b0;
        checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL squash got req=%0h ov=%0h rdy=%0h exp=0/0/1", mem_req, out_valid, in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL squash_after got ov=%0h req=%0h exp=0/0", out_valid, mem_req); end
    endtask

    task automatic test_halt();
        in_valid = 1'b1; instruction_in = I_LW; alu_in = 32'h20;
        step();
        halt = 1'b1; instruction_in = I_ADD; alu_in = 32'h55;
        step();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL halt_access_held got=%0h exp=1", mem_req); end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        checks++; if (out_valid !== 1'b1 || result_out !== 32'h1234_5678 || instruction_out !== I_LW) begin failures++; $display("FAIL halt_complete got ov=%0h res=%h ins=%h exp=1/12345678/%h", out_valid, result_out, instruction_out, I_LW); end
        checks++; if (in_ready !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL halt_ready got rdy=%0h req=%0h exp=1/0", in_ready, mem_req); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (out_valid !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL halt_block%0d got ov=%0h req=%0h rdy=%0h exp=0/0/1", i, out_valid, mem_req, in_ready); end
        end
        halt = 1'b0;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result_out !== 32'h55 || instruction_out !== I_ADD) begin failures++; $display("FAIL halt_release got ov=%0h res=%h ins=%h exp=1/55/%h", out_valid, result_out, instruction_out, I_ADD); end
        step();
    endtask

    task automatic test_reset_mid_access();
        in_valid = 1'b1; instruction_in = I_LB; alu_in = 32'h104;
        step();
        in_valid = 1'b0;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstacc_req got=%0h exp=1", mem_req); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rstacc_drop got req=%0h ov=%0h exp=0/0", mem_req, out_valid); end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result_out !== 32'h0) begin failures++; $display("FAIL rstacc_ack_ignored got ov=%0h rdy=%0h res=%h exp=0/1/0", out_valid, in_ready, result_out); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; instruction_in = I_LW; alu_in = 32'h40;
        step();
        instruction_in = I_ADD; alu_in = 32'h77;
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        step();
        mem_ack = 1'b0;
        checks++; if (out_valid !== 1'b1 || result_out !== 32'hA5A5_A5A5 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_load got ov=%0h res=%h rdy=%0h exp=1/a5a5a5a5/1", out_valid, result_out, in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result_out !== 32'h77 || instruction_out !== I_ADD || in_ready !== 1'b0) begin failures++; $display("FAIL b2b_add got ov=%0h res=%h ins=%h rdy=%0h exp=1/77/%h/0", out_valid, result_out, instruction_out, in_ready, I_ADD); end
        mem_ack = 1'b1;
        step();
        step();
        mem_ack = 1'b0;
        checks++; if (out_valid !== 1'b0 || mem_req !== 1'b0 || result_out !== 32'h77) begin failures++; $display("FAIL stray_ack got ov=%0h req=%0h res=%h exp=0/0/77", out_valid, mem_req, result_out); end
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_load_byte(I_LB,  32'hFFFF_FF80, "lb");
        test_load_byte(I_LBU, 32'h0000_0080, "lbu");
        test_store_half();
        test_misaligned();
        test_squash();
        test_halt();
        test_reset_mid_access();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog_timeout got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the RISC-V pipeline, sitting between execute and write-back. Accepts one executed instruction at a time. For LOAD/STORE it runs a request/acknowledge transaction with the data memory, generating byte enables, aligned store data and sign/zero-extended load data. For all other instructions it passes the ALU result through to the write-back stage.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- halt  in  1  pipeline halt; blocks acceptance of new instructions.
- taken_branch  in  1  squash; an instruction accepted in a cycle where this is high is dropped.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage can accept (high only in IDLE).
- instruction_in  in  XLEN  instruction word.
- alu_in  in  XLEN  ALU result; effective address for LOAD/STORE.
- rs2_in  in  XLEN  store data.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  XLEN  word address {alu_in[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_ack  in  1  memory completed the request this cycle.
- mem_rdata  in  XLEN  load data; valid when mem_ack = 1.
- out_valid  out  1  one-cycle pulse: result presented to write-back.
- instruction_out  out  XLEN  instruction that completed.
- result_out  out  XLEN  load data or ALU result.
- fault_out  out  1  misaligned access or unsupported funct3; qualified by out_valid.

## Operation
- Opcode is instruction[6:0]: LOAD = 7'b0000011, STORE = 7'b0100011. funct3 is instruction[14:12].
- **Accept:** in_valid & in_ready & !halt. If taken_branch is also high, the instruction is dropped: no request, no out_valid.
- **FSM states:**
  - IDLE: in_ready = 1.
  - ACCESS: mem_req = 1; leave on mem_ack, go to IDLE.
  - RESP: one cycle with out_valid = 1, in_ready = 0; go to IDLE.
- **Non-memory instruction:** IDLE -> RESP. result_out = alu_in, fault_out = 0.
- **Aligned LOAD/STORE with legal funct3:** IDLE -> ACCESS -> IDLE. out_valid pulses the cycle after mem_ack is sampled.
- **Misaligned or illegal access:** IDLE -> RESP with no memory request. fault_out = 1, result_out = 0.
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Legal funct3: LOAD 000/001/010/100/101; STORE 000/001/010.
- **Byte enables:** byte: 4'b0001 << addr[1:0]; half: addr[1] ? 4'b1100 : 4'b0011; word: 4'b1111. Same enables are driven for loads.
- **mem_wdata:** byte {4{rs2[7:0]}}, half {2{rs2[15:0]}}, word rs2.
- **Load extraction:** lane = mem_rdata >> (8*addr[1:0]).
  - LB/LH sign-extend lane[7:0] / lane[15:0].
  - LBU/LHU zero-extend.
  - LW passes lane unchanged.
- **Store result:** result_out = alu_in. Write-back suppresses the register write for stores.
- mem_addr, mem_we, mem_be and mem_wdata are registered at accept and held stable while mem_req = 1.
- halt and taken_branch never abort an ACCESS in flight; the transaction completes and out_valid still pulses.
- instruction_out, result_out and fault_out hold their last values between pulses.

## Timing
- **Reset (rst_n = 0 at an edge):**
  - state = IDLE.
  - Zero: mem_req, mem_we, mem_be, mem_addr, mem_wdata, out_valid, fault_out, instruction_out, result_out.
  - in_ready = 1 from the first cycle after reset.
  - Reset during ACCESS drops mem_req at that edge; the outstanding transaction is abandoned and a later mem_ack is ignored in IDLE.
- **Non-memory latency:** accept at edge N, out_valid high in cycle N..N+1, in_ready high again after edge N+1.
- **Memory latency:**
  - mem_req rises after accept edge N.
  - If mem_ack is sampled high at edge M (M ≥ N+1), out_valid is high and mem_req low after M; in_ready is high in that same cycle.
  - Zero-wait memory: 2 cycles from accept to out_valid.
- Back-to-back accept of a new instruction in the out_valid cycle of a memory access is permitted.
- mem_ack outside ACCESS is ignored.
- There is no backpressure from write-back.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 and mem_ack = 1 -> all outputs 0, no mem_req, in_ready = 1 after release.
- ADD, alu_in = 0x0000_1234, no halt -> out_valid one cycle later, result_out = 0x0000_1234, fault_out = 0, mem_req never asserted.
- LB at addr 0x103, mem_rdata = 0x80FF_0011, ack after 3 wait cycles -> mem_addr = 0x100, mem_be = 4'b1000, mem_req held 3 cycles, result_out = 0xFFFF_FF80.
  - Repeat with LBU -> result_out = 0x0000_0080.
- SH at addr 0x2002, rs2 = 0xDEAD_BEEF -> mem_we = 1, mem_be = 4'b1100, mem_wdata = 0xBEEF_BEEF, result_out = 0x2002.
- LW at addr 0x0000_0006 -> no mem_req, out_valid next cycle, fault_out = 1, result_out = 0.
- Squash and halt cases:
  - LW accepted with taken_branch = 1 -> no request, no out_valid.
  - halt = 1 asserted during ACCESS -> transaction completes with out_valid, then in_ready = 1 but no accept until halt = 0.
